// File: rtl/stp_seq_gen.sv
// Stop-pulse sequence generator: a one-cycle lead window, a train of
// evenly spaced stop pulses, an optional block-flag phase, then a done pulse.
module stp_seq_gen #(
  parameter int BIT_W = 5,
  parameter int GAP_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [BIT_W-1:0] stop_num_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic [GAP_W-1:0] blk_len_i,
  output logic             som_o,
  output logic             stop_o,
  output logic             blkf_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [BIT_W-1:0] sent_cnt_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_MEAS = 3'd2;
  localparam logic [2:0] S_BLK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [BIT_W-1:0] stop_num_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] blk_len_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] blk_cnt;

  logic [BIT_W:0] sent_next;
  logic           last_pulse;
  logic           enter_tail;

  // Widened by one bit so the final-pulse compare cannot alias on wrap.
  assign sent_next  = {1'b0, sent_cnt_o} + (BIT_W+1)'(1);
  assign last_pulse = stop_o && (sent_next == {1'b0, stop_num_q});

  // Leaving the pulse phase: straight from LEAD when no pulses are requested,
  // otherwise on the cycle that carries the final pulse.
  always_comb begin
    enter_tail = 1'b0;
    if (state == S_LEAD && stop_num_q == '0) enter_tail = 1'b1;
    if (state == S_MEAS && last_pulse)       enter_tail = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      stop_num_q <= '0;
      gap_q      <= '0;
      blk_len_q  <= '0;
      gap_cnt    <= '0;
      blk_cnt    <= '0;
      som_o      <= 1'b0;
      stop_o     <= 1'b0;
      blkf_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      sent_cnt_o <= '0;
    end else begin
      // NOTE: these non-blocking defaults are overridden by any later
      // assignment in this block; the last scheduled value wins at the edge.
      stop_o <= 1'b0;
      done_o <= 1'b0;
      if (stop_o && !(&sent_cnt_o)) sent_cnt_o <= sent_cnt_o + BIT_W'(1);

      if (state != S_IDLE && abort_i) begin
        state  <= S_IDLE;
        som_o  <= 1'b0;
        blkf_o <= 1'b0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              stop_num_q <= stop_num_i;
              gap_q      <= gap_i;
              blk_len_q  <= blk_len_i;
              sent_cnt_o <= '0;
              state      <= S_LEAD;
              som_o      <= 1'b1;
              busy_o     <= 1'b1;
            end
          end
          S_LEAD: begin
            if (!enter_tail) begin
              state  <= S_MEAS;
              stop_o <= 1'b1;
            end
          end
          S_MEAS: begin
            if (stop_o) begin
              if (!last_pulse) begin
                if (gap_q == '0) stop_o <= 1'b1;
                else             gap_cnt <= gap_q;
              end
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
              if (gap_cnt == GAP_W'(1)) stop_o <= 1'b1;
            end
          end
          S_BLK: begin
            if (blk_cnt == GAP_W'(1)) begin
              state  <= S_DONE;
              blkf_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              blk_cnt <= blk_cnt - GAP_W'(1);
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            som_o  <= 1'b0;
            blkf_o <= 1'b0;
            busy_o <= 1'b0;
          end
        endcase

        if (enter_tail) begin
          som_o <= 1'b0;
          if (blk_len_q == '0) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else begin
            state   <= S_BLK;
            blkf_o  <= 1'b1;
            blk_cnt <= blk_len_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stp_seq_gen.sv
// Directed bench for stp_seq_gen: cycle-by-cycle traces against hand-derived
// expectations for the normal, zero, back-to-back, abort and reset scenarios.
module tb_stp_seq_gen;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [4:0] stop_num_i = '0;
  logic [3:0] gap_i = '0;
  logic [3:0] blk_len_i = '0;
  logic       som_o, stop_o, blkf_o, busy_o, done_o;
  logic [4:0] sent_cnt_o;

  int checks = 0;
  int errors = 0;
  int mon_stops = 0;
  logic [4:0] exp_flags;
  logic [4:0] exp_sent;

  stp_seq_gen dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .stop_num_i (stop_num_i),
    .gap_i      (gap_i),
    .blk_len_i  (blk_len_i),
    .som_o      (som_o),
    .stop_o     (stop_o),
    .blkf_o     (blkf_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sent_cnt_o (sent_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Start is high in cycle 0; returns sampling cycle 1.
  task automatic launch(input logic [4:0] num, input logic [3:0] gap, input logic [3:0] blk);
    stop_num_i = num;
    gap_i      = gap;
    blk_len_i  = blk;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
    mon_stops  = 0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    start_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({som_o, stop_o, blkf_o, busy_o, done_o} !== 5'b0 || sent_cnt_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold flags %b sent %0d, expected 00000 sent 0",
               {som_o, stop_o, blkf_o, busy_o, done_o}, sent_cnt_o);
    end
    rst_i   = 1'b0;
    start_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy %b, expected 0", busy_o);
    end
  endtask

  task automatic test_normal();
    launch(5'd3, 4'd1, 4'd4);
    // Changes after launch must not disturb the running sequence.
    stop_num_i = 5'd9;
    gap_i      = 4'd7;
    blk_len_i  = 4'd0;
    for (int c = 1; c <= 14; c++) begin
      exp_flags = {c <= 6, c == 2 || c == 4 || c == 6, c >= 7 && c <= 10, c <= 11, c == 11};
      exp_sent  = (c <= 2) ? 5'd0 : (c <= 4) ? 5'd1 : (c <= 6) ? 5'd2 : 5'd3;
      checks++;
      if ({som_o, stop_o, blkf_o, busy_o, done_o} !== exp_flags) begin
        errors++;
        $display("FAIL normal_flags cycle %0d got %b expected %b", c,
                 {som_o, stop_o, blkf_o, busy_o, done_o}, exp_flags);
      end
      checks++;
      if (sent_cnt_o !== exp_sent) begin
        errors++;
        $display("FAIL normal_sent cycle %0d got %0d expected %0d", c, sent_cnt_o, exp_sent);
      end
      if (stop_o && som_o && !blkf_o) mon_stops++;
      if (done_o) begin
        checks++;
        if (mon_stops != 3) begin
          errors++;
          $display("FAIL normal_pulse_count got %0d expected 3", mon_stops);
        end
      end
      tick();
    end
  endtask

  task automatic test_zero();
    launch(5'd0, 4'd3, 4'd0);
    for (int c = 1; c <= 4; c++) begin
      exp_flags = {c == 1, 1'b0, 1'b0, c <= 2, c == 2};
      checks++;
      if ({som_o, stop_o, blkf_o, busy_o, done_o} !== exp_flags || sent_cnt_o !== 5'd0) begin
        errors++;
        $display("FAIL zero_flags cycle %0d got %b sent %0d expected %b sent 0", c,
                 {som_o, stop_o, blkf_o, busy_o, done_o}, sent_cnt_o, exp_flags);
      end
      if (stop_o && som_o && !blkf_o) mon_stops++;
      if (done_o) begin
        checks++;
        if (mon_stops != 0) begin
          errors++;
          $display("FAIL zero_pulse_count got %0d expected 0", mon_stops);
        end
      end
      tick();
    end
    launch(5'd0, 4'd0, 4'd2);
    for (int c = 1; c <= 6; c++) begin
      exp_flags = {c == 1, 1'b0, c == 2 || c == 3, c <= 4, c == 4};
      checks++;
      if ({som_o, stop_o, blkf_o, busy_o, done_o} !== exp_flags) begin
        errors++;
        $display("FAIL zero_blk_flags cycle %0d got %b expected %b", c,
                 {som_o, stop_o, blkf_o, busy_o, done_o}, exp_flags);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    launch(5'd31, 4'd0, 4'd1);
    for (int c = 1; c <= 36; c++) begin
      exp_flags = {c <= 32, c >= 2 && c <= 32, c == 33, c <= 34, c == 34};
      exp_sent  = (c <= 2) ? 5'd0 : (c - 2 > 31) ? 5'd31 : 5'(c - 2);
      checks++;
      if ({som_o, stop_o, blkf_o, busy_o, done_o} !== exp_flags) begin
        errors++;
        $display("FAIL b2b_flags cycle %0d got %b expected %b", c,
                 {som_o, stop_o, blkf_o, busy_o, done_o}, exp_flags);
      end
      checks++;
      if (sent_cnt_o !== exp_sent) begin
        errors++;
        $display("FAIL b2b_sent cycle %0d got %0d expected %0d", c, sent_cnt_o, exp_sent);
      end
      if (stop_o && som_o && !blkf_o) mon_stops++;
      if (done_o) begin
        checks++;
        if (mon_stops != 31) begin
          errors++;
          $display("FAIL b2b_pulse_count got %0d expected 31", mon_stops);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    launch(5'd5, 4'd2, 4'd3);
    for (int c = 1; c <= 10; c++) begin
      abort_i   = (c == 6);
      exp_flags = (c <= 6) ? {1'b1, c == 2 || c == 5, 1'b0, 1'b1, 1'b0} : 5'b0;
      exp_sent  = (c <= 2) ? 5'd0 : (c <= 5) ? 5'd1 : 5'd2;
      checks++;
      if ({som_o, stop_o, blkf_o, busy_o, done_o} !== exp_flags) begin
        errors++;
        $display("FAIL abort_flags cycle %0d got %b expected %b", c,
                 {som_o, stop_o, blkf_o, busy_o, done_o}, exp_flags);
      end
      checks++;
      if (sent_cnt_o !== exp_sent) begin
        errors++;
        $display("FAIL abort_sent cycle %0d got %0d expected %0d", c, sent_cnt_o, exp_sent);
      end
      tick();
    end
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (busy_o !== 1'b0 || som_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_start_idle step %0d busy %b som %b expected 0 0", c, busy_o, som_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_and_held_start();
    launch(5'd1, 4'd0, 4'd3);
    for (int c = 1; c <= 8; c++) begin
      rst_i = (c == 4);
      if (c <= 4) exp_flags = {c <= 2, c == 2, c >= 3, 1'b1, 1'b0};
      else        exp_flags = 5'b0;
      exp_sent = (c <= 2 || c >= 5) ? 5'd0 : 5'd1;
      checks++;
      if ({som_o, stop_o, blkf_o, busy_o, done_o} !== exp_flags || sent_cnt_o !== exp_sent) begin
        errors++;
        $display("FAIL rst_mid cycle %0d got %b sent %0d expected %b sent %0d", c,
                 {som_o, stop_o, blkf_o, busy_o, done_o}, sent_cnt_o, exp_flags, exp_sent);
      end
      tick();
    end
    rst_i = 1'b0;
    launch(5'd2, 4'd0, 4'd0);
    for (int c = 1; c <= 8; c++) begin
      // start_i stays high through the DONE cycle and drops before IDLE.
      start_i   = (c <= 4);
      exp_flags = {c <= 3, c == 2 || c == 3, 1'b0, c <= 4, c == 4};
      exp_sent  = (c <= 2) ? 5'd0 : (c == 3) ? 5'd1 : 5'd2;
      checks++;
      if ({som_o, stop_o, blkf_o, busy_o, done_o} !== exp_flags || sent_cnt_o !== exp_sent) begin
        errors++;
        $display("FAIL held_start cycle %0d got %b sent %0d expected %b sent %0d", c,
                 {som_o, stop_o, blkf_o, busy_o, done_o}, sent_cnt_o, exp_flags, exp_sent);
      end
      if (stop_o && som_o && !blkf_o) mon_stops++;
      if (done_o) begin
        checks++;
        if (mon_stops != 2) begin
          errors++;
          $display("FAIL held_start_pulse_count got %0d expected 2", mon_stops);
        end
      end
      tick();
    end
    start_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid_and_held_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
